// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, inst} pairs between the IF and ID stages.
// A full queue drops if_ready to stall the PC; pushes attempted while full raise a sticky ovf_err.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_inst,
    output logic                     if_ready,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_pc4,
    output logic [31:0]              id_inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];

    logic          push;
    logic          pop;
    logic [63:0]   head_entry;

    // Handshake flags derive from registered state only, so reset reaches them without a clock.
    always_comb begin
        if_ready   = (count_q != CntFull);
        id_valid   = (count_q != '0);
        push       = if_valid && if_ready && !flush;
        pop        = id_valid && id_ready && !flush;
        head_entry = mem_q[head_q];
        id_pc      = id_valid ? head_entry[63:32] : 32'h0;
        id_inst    = id_valid ? head_entry[31:0] : 32'h0;
        id_pc4     = id_valid ? (head_entry[63:32] + 32'd4) : 32'h0;
        count      = count_q;
        ovf_err    = ovf_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        ovf_d   = ovf_q | (if_valid & ~if_ready & ~flush);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = {if_pc, if_inst};
                tail_d        = tail_q + PtrOne;
            end
            if (pop) begin
                head_d = head_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload storage is deliberately unreset; empty-state outputs are masked above.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a table of vectors plus hand sequences, with a
// scoreboard queue of {pc, inst} pairs predicting the head entry each cycle.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic [2:0]  count;
    logic        ovf_err;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .id_inst  (id_inst),
        .count    (count),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    int          mcount  = 0;
    logic        movf    = 1'b0;
    logic [63:0] sb[$];

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Drive one cycle, check pre-edge outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        logic [31:0] inst;
        logic [31:0] epc;
        logic [31:0] epc4;
        logic [63:0] head;
        logic        push;
        logic        pop;
        inst     = $urandom;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        @(negedge clk);
        check("count", count, mcount);
        check("if_ready", if_ready, mcount != DEPTH);
        check("id_valid", id_valid, mcount != 0);
        check("ovf_err", ovf_err, movf);
        if (mcount != 0) begin
            head = sb[0];
            epc  = head[63:32];
            epc4 = epc + 32'd4;
            check("id_pc", id_pc, epc);
            check("id_inst", id_inst, head[31:0]);
            check("id_pc4", id_pc4, epc4);
        end else begin
            check("empty_pc", id_pc, 0);
            check("empty_inst", id_inst, 0);
            check("empty_pc4", id_pc4, 0);
        end
        push = v && (mcount != DEPTH) && !fl;
        pop  = (mcount != 0) && rdy && !fl;
        if (v && mcount == DEPTH && !fl) movf = 1'b1;
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                mcount--;
            end
            if (push) begin
                sb.push_back({pc, inst});
                mcount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 32'd0,  1'b0, 1'b0, 3'd1};
        tbl[1] = '{1'b1, 32'd4,  1'b0, 1'b0, 3'd2};
        tbl[2] = '{1'b1, 32'd8,  1'b0, 1'b0, 3'd3};
        tbl[3] = '{1'b1, 32'd12, 1'b0, 1'b0, 3'd4};
        tbl[4] = '{1'b1, 32'd16, 1'b0, 1'b0, 3'd4};  // push while full
        tbl[5] = '{1'b0, 32'd0,  1'b1, 1'b0, 3'd3};
        tbl[6] = '{1'b0, 32'd0,  1'b1, 1'b0, 3'd2};
        tbl[7] = '{1'b0, 32'd0,  1'b1, 1'b0, 3'd1};
        tbl[8] = '{1'b0, 32'd0,  1'b1, 1'b0, 3'd0};
        tbl[9] = '{1'b0, 32'd0,  1'b1, 1'b0, 3'd0};  // id_ready while empty

        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_if_ready", if_ready, 1);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_pc4", id_pc4, 0);
        check("rst_id_inst", id_inst, 0);
        check("rst_ovf", ovf_err, 0);
        rst = 1'b0;

        // Fill, overflow attempt, drain in order, pop while empty.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].pc, tbl[i].rdy, tbl[i].fl);
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
        end
        check("ovf_sticky", ovf_err, 1);

        // Streaming with simultaneous push and pop across pointer wrap.
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h204 + 32'(4 * i), 1'b1, 1'b0);
            check("stream_count", count, 1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with 3 entries while pushing and popping.
        cycle(1'b1, 32'h20, 1'b0, 1'b0);
        cycle(1'b1, 32'h24, 1'b0, 1'b0);
        cycle(1'b1, 32'h28, 1'b0, 1'b0);
        cycle(1'b1, 32'h2c, 1'b1, 1'b1);
        check("flush_count", count, 0);
        check("flush_id_valid", id_valid, 0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0);
        check("post_flush_pc", id_pc, 32'h100);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with 2 entries queued.
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 1'b0, 1'b0);
        if_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_if_ready", if_ready, 1);
        check("arst_id_valid", id_valid, 0);
        check("arst_id_pc", id_pc, 0);
        check("arst_id_inst", id_inst, 0);
        check("arst_ovf", ovf_err, 0);
        rst = 1'b0;
        sb.delete();
        mcount = 0;
        movf   = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'h400, 1'b0, 1'b0);
        check("post_rst_pc", id_pc, 32'h400);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
